// File: rtl/ripple_ca.sv
// Registered ripple-carry adder built from a chain of one-bit full-adder cells.
// Produces sum, carry-out and two's-complement overflow one cycle after sampling.
module ripple_ca #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sumout,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_valid;

  assign w_c[0] = cin;

  // Carry ripples cell to cell; no lookahead, so the chain stays explicit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign w_s[gi]   = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (a[gi] & b[gi]) | (a[gi] & w_c[gi]) | (b[gi] & w_c[gi]);
    end
  endgenerate

  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign sumout    = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_ripple_ca.sv
// Self-checking bench for ripple_ca: directed cases, exhaustive sweep and
// randomized traffic compared against an arithmetic reference model.
module tb_ripple_ca;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sumout;
  logic         cout;
  logic         ovf;
  logic         out_valid;

  int n_tests;
  int n_fail;

  // Reference state: what the outputs should show after the latest edge.
  logic [W-1:0] m_sum;
  logic         m_cout;
  logic         m_ovf;
  logic         m_valid;

  ripple_ca #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .sumout   (sumout),
    .cout     (cout),
    .ovf      (ovf),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                            input logic tc, input logic tv, input logic tr);
    int   total;
    logic sa, sb, ss;
    if (!tr) begin
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    end else if (tv) begin
      total   = int'(ta) + int'(tb_in) + int'(tc);
      m_sum   = total[W-1:0];
      m_cout  = (total >= (1 << W));
      sa      = ta[W-1];
      sb      = tb_in[W-1];
      ss      = m_sum[W-1];
      m_ovf   = (sa == sb) && (ss != sa);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    n_tests++;
    assert (sumout === m_sum) else begin
      n_fail++;
      $error("FAIL %s sumout: got %b expected %b", tag, sumout, m_sum);
    end
    n_tests++;
    assert (cout === m_cout) else begin
      n_fail++;
      $error("FAIL %s cout: got %b expected %b", tag, cout, m_cout);
    end
    n_tests++;
    assert (ovf === m_ovf) else begin
      n_fail++;
      $error("FAIL %s ovf: got %b expected %b", tag, ovf, m_ovf);
    end
    n_tests++;
    assert (out_valid === m_valid) else begin
      n_fail++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, m_valid);
    end
  endtask

  task automatic step(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_in,
                      input logic tc, input logic tv, input logic tr);
    a = ta; b = tb_in; cin = tc; in_valid = tv; rst_n = tr;
    @(posedge clk);
    model_edge(ta, tb_in, tc, tv, tr);
    #1;
    check(tag);
  endtask

  // Directed expectations taken straight from the worked examples.
  task automatic expect_fixed(input string tag, input logic [W-1:0] es,
                              input logic ec, input logic eo, input logic ev);
    n_tests++;
    assert ({sumout, cout, ovf, out_valid} === {es, ec, eo, ev}) else begin
      n_fail++;
      $error("FAIL %s fixed: got s=%b c=%b o=%b v=%b expected s=%b c=%b o=%b v=%b",
             tag, sumout, cout, ovf, out_valid, es, ec, eo, ev);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; rst_n = 1'b0;

    step("reset0", 4'b1011, 4'b0110, 1'b1, 1'b1, 1'b0);
    step("reset1", 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
    expect_fixed("reset_fixed", 4'b0000, 1'b0, 1'b0, 1'b0);

    step("neg_ovf", 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1);
    expect_fixed("neg_ovf_fixed", 4'b0000, 1'b1, 1'b1, 1'b1);
    step("mix_ovf", 4'b1000, 4'b1111, 1'b0, 1'b1, 1'b1);
    expect_fixed("mix_ovf_fixed", 4'b0111, 1'b1, 1'b1, 1'b1);
    step("no_ovf", 4'b0010, 4'b1000, 1'b0, 1'b1, 1'b1);
    expect_fixed("no_ovf_fixed", 4'b1010, 1'b0, 1'b0, 1'b1);
    step("ripple_all", 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);
    expect_fixed("ripple_all_fixed", 4'b0000, 1'b1, 1'b0, 1'b1);
    step("ripple_pos", 4'b0111, 4'b0000, 1'b1, 1'b1, 1'b1);
    expect_fixed("ripple_pos_fixed", 4'b1000, 1'b0, 1'b1, 1'b1);

    step("hold0", 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1);
    expect_fixed("hold0_fixed", 4'b1000, 1'b0, 1'b1, 1'b0);
    step("hold1", 4'b1110, 4'b0011, 1'b1, 1'b0, 1'b1);
    step("rst_prio", 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b0);
    expect_fixed("rst_prio_fixed", 4'b0000, 1'b0, 1'b0, 1'b0);
    step("post_rst", 4'b0011, 4'b0100, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 512; i++) begin
      step("sweep", i[3:0], i[7:4], i[8], 1'b1, 1'b1);
    end

    for (int i = 0; i < 300; i++) begin
      step("random", W'($urandom), W'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
